seq_mult_arb: RTL and testbench

Shared controller for the 4-bit shift-and-add sequential multiplier. It accepts multiply requests from two requesters and arbitrates between them round-robin. It sequences the accumulator/shift datapath through its per-bit steps and returns the 2·WIDTH-bit unsigned product tagged with the requester ID. It sits between the operand sources and the single multiplier datapath, so one multiplier serves two clients.

---
 rtl/seq_mult_arb_pkg.sv | 17 +
 rtl/seq_mult_arb_dp.sv | 60 ++++++
 rtl/seq_mult_arb.sv | 163 ++++++++++++++++
 tb/tb_seq_mult_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_arb_pkg.sv
// Shared definitions for the arbitrated shift-and-add multiplier:
// FSM encodings, default operand width and step-counter sizing.
package seq_mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_arb_dp.sv
// Shift-and-add datapath: M, A, C, Q registers and the WIDTH+1 bit adder.
// step_product is the {A,Q} value the current step will leave behind.
module seq_mult_dp
  import seq_mult_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] step_product
);

  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic             c_r;
  logic [WIDTH:0]   sum_s;
  logic [2*WIDTH:0] shift_s;

  // Conditional add of M into {C,A}, then one-bit right shift of {C,A,Q} with C cleared.
  always_comb begin
    sum_s = {(WIDTH+1){1'b0}};
    if (q_r[0]) begin
      sum_s = {c_r, a_r} + {1'b0, m_r};
    end else begin
      sum_s = {c_r, a_r};
    end
    shift_s      = {1'b0, sum_s, q_r[WIDTH-1:1]};
    step_product = shift_s[2*WIDTH-1:0];
  end

  // Datapath registers: load clears the accumulator, step commits one shift-add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_r <= {WIDTH{1'b0}};
      a_r <= {WIDTH{1'b0}};
      q_r <= {WIDTH{1'b0}};
      c_r <= 1'b0;
    end else if (load) begin
      m_r <= mcand;
      q_r <= mplier;
      a_r <= {WIDTH{1'b0}};
      c_r <= 1'b0;
    end else if (step) begin
      c_r <= shift_s[2*WIDTH];
      a_r <= shift_s[2*WIDTH-1:WIDTH];
      q_r <= shift_s[WIDTH-1:0];
    end else begin
      m_r <= m_r;
      a_r <= a_r;
      q_r <= q_r;
      c_r <= c_r;
    end
  end

endmodule

// File: rtl/seq_mult_arb.sv
// Two-requester round-robin front end for one sequential multiplier:
// grants in IDLE, runs WIDTH steps, returns a tagged product for one cycle.
module seq_mult_arb
  import seq_mult_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [WIDTH-1:0]   m0,
  input  logic [WIDTH-1:0]   q0,
  input  logic [WIDTH-1:0]   m1,
  input  logic [WIDTH-1:0]   q1,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  output logic               out_id
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t             state_r;
  state_t             state_s;
  logic [CW-1:0]      cnt_r;
  logic               last_r;
  logic               id_r;
  logic               busy_r;
  logic [2*WIDTH-1:0] out_r;
  logic               out_valid_r;
  logic               out_id_r;

  logic               idle_s;
  logic               win_s;
  logic               load_s;
  logic               step_s;
  logic               done_step_s;
  logic [WIDTH-1:0]   mcand_s;
  logic [WIDTH-1:0]   mplier_s;
  logic [2*WIDTH-1:0] step_product_s;

  // The unused encoding behaves as IDLE so a corrupted state can still grant.
  assign idle_s = (state_r != RUN) && (state_r != DONE);

  // Round-robin grant: a tie goes to the requester that did not win last time.
  always_comb begin
    gnt = 2'b00;
    if (reset && idle_s) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if (last_r) begin
            gnt = 2'b01;
          end else begin
            gnt = 2'b10;
          end
        end
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Operand select and datapath strobes.
  always_comb begin
    win_s  = gnt[1];
    load_s = |gnt;
    if (win_s) begin
      mcand_s  = m1;
      mplier_s = q1;
    end else begin
      mcand_s  = m0;
      mplier_s = q0;
    end
    step_s      = (state_r == RUN);
    done_step_s = step_s && (cnt_r == LAST_STEP);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (done_step_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: begin
        if (load_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      last_r      <= 1'b1;
      id_r        <= 1'b0;
      busy_r      <= 1'b0;
      out_r       <= {(2*WIDTH){1'b0}};
      out_valid_r <= 1'b0;
      out_id_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s == RUN) || (state_s == DONE);
      out_valid_r <= done_step_s;
      if (load_s) begin
        cnt_r  <= {CW{1'b0}};
        id_r   <= win_s;
        last_r <= win_s;
      end else if (step_s) begin
        cnt_r  <= cnt_r + CW'(1);
      end else begin
        cnt_r  <= cnt_r;
      end
      if (done_step_s) begin
        out_r    <= step_product_s;
        out_id_r <= id_r;
      end else begin
        out_r    <= out_r;
        out_id_r <= out_id_r;
      end
    end
  end

  assign busy      = busy_r;
  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign out_id    = out_id_r;

  seq_mult_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk          (clk),
    .reset        (reset),
    .load         (load_s),
    .step         (step_s),
    .mcand        (mcand_s),
    .mplier       (mplier_s),
    .step_product (step_product_s)
  );

endmodule

// File: tb/tb_seq_mult_arb.sv
// Scoreboard bench for seq_mult_arb: stimulus pushes hand-computed products
// with their due cycle, a monitor pops and compares on every out_valid.
module tb_seq_mult_arb;

  typedef struct {
    logic [7:0] prod;
    logic       id;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [3:0] m0, q0, m1, q1;
  logic [1:0] gnt;
  logic       busy;
  logic [7:0] out;
  logic       out_valid;
  logic       out_id;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_mult_arb #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .m0        (m0),
    .q0        (q0),
    .m1        (m1),
    .q1        (q1),
    .gnt       (gnt),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_gnt(input int i, output int g);
    bit ok;
    ok = 1'b0;
    g  = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (gnt[i]) begin
        ok = 1'b1;
        g  = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic op(input int i, input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp);
    int g;
    int n;
    if (i == 0) begin
      m0 = m; q0 = q;
    end else begin
      m1 = m; q1 = q;
    end
    req[i] = 1'b1;
    wait_gnt(i, g);
    sb.push_back('{prod: exp, id: i[0], due: g + 5});
    @(negedge clk);
    chk("gnt_one_cycle", {30'd0, gnt}, 32'd0);
    req[i] = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 32'd5);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int   g, gprev;
    exp_t e;
    reset = 1'b0;
    req   = 2'b01;
    m0 = 4'd0; q0 = 4'd0; m1 = 4'd0; q1 = 4'd0;
    fork
      begin
        // Reset state, with a request pending to show the grant is masked.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        req   = 2'b00;
        reset = 1'b1;
        @(negedge clk);

        op(0, 4'b1011, 4'b1101, 8'h8F);
        op(1, 4'b0011, 4'b1000, 8'h18);

        // Both requesting from a fresh reset: 0 first, then alternating.
        do_reset();
        m0 = 4'hF; q0 = 4'hF; m1 = 4'h0; q1 = 4'h9;
        req = 2'b11;
        gprev = 0;
        for (int k = 0; k < 4; k++) begin
          wait_gnt(k % 2, g);
          chk("rr_gnt", {30'd0, gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
          sb.push_back('{prod: (k % 2 == 0) ? 8'hE1 : 8'h00, id: k[0], due: g + 5});
          if (k > 0) chk("rr_spacing", g - gprev, 32'd6);
          gprev = g;
          @(negedge clk);
        end
        req = 2'b00;
        wait_idle();

        // Requester 1 arrives mid-run and must wait for DONE.
        m0 = 4'd5; q0 = 4'd3; req[0] = 1'b1;
        wait_gnt(0, g);
        sb.push_back('{prod: 8'h0F, id: 1'b0, due: g + 5});
        gprev = g;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        m1 = 4'd6; q1 = 4'd7; req[1] = 1'b1;
        wait_gnt(1, g);
        chk("late_gnt_cycle", g - gprev, 32'd6);
        sb.push_back('{prod: 8'h2A, id: 1'b1, due: g + 5});
        @(negedge clk);
        req[1] = 1'b0;
        wait_idle();

        // Reset in the third RUN cycle discards the operation.
        m0 = 4'hB; q0 = 4'hD; req[0] = 1'b1;
        wait_gnt(0, g);
        @(negedge clk);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_out", {24'd0, out}, 32'd0);
        chk("abort_id", {31'd0, out_id}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        op(0, 4'd7, 4'd9, 8'h3F);

        op(0, 4'd0, 4'd0, 8'h00);
        op(0, 4'd1, 4'd1, 8'h01);

        repeat (8) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
      end
      begin
        forever begin
          @(negedge clk);
          chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
          chk("gnt_while_busy", {31'd0, (|gnt) & busy}, 32'd0);
          if (out_valid) begin
            if (sb.size() == 0) begin
              chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else begin
              e = sb.pop_front();
              chk("product", {24'd0, out}, {24'd0, e.prod});
              chk("out_id", {31'd0, out_id}, {31'd0, e.id});
              chk("latency", cyc, e.due);
            end
          end
          if (cyc > 5000) begin
            $display("FAIL watchdog actual=%0d required<=5000", cyc);
            $fatal(1, "watchdog expired");
          end
        end
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
